stream_demux: RTL and testbench

Valid/ready stream demultiplexer: one input stream carries a destination index with each beat, and the block routes the beat to one of `N_OUT` output channels. Each output has a one-entry registered holding slot, so outputs are registered and backpressure is per-channel. It is the inverse of the selector-driven mux primitives. The block sits between a single producer and several independent consumers.

---
 rtl/stream_demux_pkg.sv | 10 +
 rtl/demux_slot.sv | 27 ++
 rtl/stream_demux.sv | 96 +++++++++
 tb/tb_stream_demux.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - default parameters and counter width for stream_demux
package stream_demux_pkg;

    localparam int N_OUT_DEF  = 3;
    localparam int W_DEF      = 8;
    localparam int DEST_W_DEF = 2;
    localparam int CNT_W      = 16;
    localparam int DROP_W     = 8;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register for a single demux output channel
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data
);

    // A load wins over a pop, so a same-cycle pop+load leaves the slot full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - valid/ready demux to N_OUT registered slots; STREAM_DEMUX_ERR_EN adds err/drop_cnt
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int N_OUT  = N_OUT_DEF,
    parameter int W      = W_DEF,
    parameter int DEST_W = DEST_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [DEST_W-1:0]    in_dest,
    output logic [N_OUT-1:0]     out_valid,
    input  logic [N_OUT-1:0]     out_ready,
    output logic [N_OUT*W-1:0]   out_data,
    output logic [CNT_W-1:0]     beat_cnt,
    output logic                 err
`ifdef STREAM_DEMUX_ERR_EN
    ,
    output logic [DROP_W-1:0]    drop_cnt
`endif
);

    localparam logic [DEST_W:0] N_OUT_EXT = (DEST_W + 1)'(N_OUT);

    logic             in_range;
    logic             sel_valid;
    logic             sel_ready;
    logic             accept;
    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] pop;

    assign in_range = {1'b0, in_dest} < N_OUT_EXT;

    always_comb begin
        hit       = '0;
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_dest == DEST_W'(i)) begin
                hit[i]    = 1'b1;
                sel_valid = out_valid[i];
                sel_ready = out_ready[i];
            end
        end
    end

    // Out-of-range beats are always consumed so a bad index can never stall the producer.
    assign in_ready = !in_range || !sel_valid || sel_ready;
    assign accept   = in_valid && in_ready && in_range;
    assign load     = {N_OUT{accept}} & hit;
    assign pop      = out_valid & out_ready;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .pop       (pop[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

`ifdef STREAM_DEMUX_ERR_EN
    logic drop;
    assign drop = in_valid && !in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux with per-channel reference queues
module tb_stream_demux;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic [1:0]   in_dest = '0;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready = '0;
    logic [N*8-1:0] out_data;
    logic [15:0]  beat_cnt;
    logic         err;
`ifdef STREAM_DEMUX_ERR_EN
    logic [7:0]   drop_cnt;
`endif

    stream_demux #(.N_OUT(N), .W(8), .DEST_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt),
        .err       (err)
`ifdef STREAM_DEMUX_ERR_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: pending beats per channel (capacity one) plus counters.
    logic [7:0]  exp_q [N][$];
    logic [15:0] beat_model = '0;
    logic        err_model  = 1'b0;
    int          drop_model = 0;
    logic        acc_pend   = 1'b0;
    logic        drop_pend  = 1'b0;
    int          pend_dest  = 0;
    logic [7:0]  pend_data  = '0;
    logic        in_reset   = 1'b1;
    logic        hold       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic apply_pending();
        if (acc_pend) begin
            exp_q[pend_dest].push_back(pend_data);
            beat_model++;
        end
        if (drop_pend) begin
`ifdef STREAM_DEMUX_ERR_EN
            err_model = 1'b1;
            if (drop_model < 255) drop_model++;
`endif
        end
        acc_pend  = 1'b0;
        drop_pend = 1'b0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] dst, input logic [N-1:0] rdy);
        logic exp_ready;
        logic in_rng;
        @(posedge clk);
        #1;
        apply_pending();
        chk("beat_cnt", 32'(beat_cnt), 32'(beat_model));
        chk("err", 32'(err), 32'(err_model));
`ifdef STREAM_DEMUX_ERR_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(drop_model));
`endif
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        out_ready = rdy;
        #1;
        in_rng    = (int'(dst) < N);
        exp_ready = !in_rng || (exp_q[dst].size() == 0) || rdy[dst];
        chk($sformatf("in_ready_dest%0d", dst), 32'(in_ready), 32'(exp_ready));
        acc_pend  = v && exp_ready && in_rng;
        drop_pend = v && !in_rng;
        pend_dest = int'(dst);
        pend_data = d;
        hold      = v && !exp_ready;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        apply_pending();
        rst       = 1'b1;
        in_reset  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        in_dest   = 2'd0;
        out_ready = '1;
        for (int c = 0; c < N; c++) exp_q[c].delete();
        beat_model = '0;
        err_model  = 1'b0;
        drop_model = 0;
        hold       = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_reset = 1'b0;
        in_valid = 1'b0;
        out_ready = '0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
    endtask

    // Monitor: compares slot state to the model and retires popped beats.
    always @(negedge clk) begin
        if (!in_reset) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("out_valid_ch%0d", c), 32'(out_valid[c]), 32'(exp_q[c].size() != 0));
                if (out_valid[c] && exp_q[c].size() != 0) begin
                    chk($sformatf("out_data_ch%0d", c), 32'(out_data[c*8 +: 8]), 32'(exp_q[c][0]));
                    if (out_ready[c]) void'(exp_q[c].pop_front());
                end
            end
        end
    end

    initial begin
        logic       v;
        logic [7:0] d;
        logic [1:0] dst;
        do_reset();
        for (int i = 0; i < N; i++) step(1'b0, 8'h00, 2'(i), 3'b000);

        step(1'b1, 8'h11, 2'd0, 3'b000);
        step(1'b1, 8'h22, 2'd1, 3'b000);
        step(1'b1, 8'h33, 2'd2, 3'b000);
        step(1'b1, 8'h44, 2'd1, 3'b000);
        chk("blocked_4th_beat", 32'(in_ready), 32'd0);
        step(1'b1, 8'h44, 2'd1, 3'b010);
        chk("pass_through_ready", 32'(in_ready), 32'd1);
        step(1'b0, 8'h00, 2'd0, 3'b000);

        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 2'd2, 3'b100);
        step(1'b0, 8'h00, 2'd0, 3'b100);

        step(1'b1, 8'h55, 2'd3, 3'b000);
        step(1'b0, 8'h00, 2'd0, 3'b000);
        step(1'b0, 8'h00, 2'd0, 3'b000);

        do_reset();
        step(1'b1, 8'hA0, 2'd0, 3'b000);
        step(1'b1, 8'hA1, 2'd1, 3'b000);
        step(1'b1, 8'hA2, 2'd2, 3'b000);
        step(1'b1, 8'hA3, 2'd0, 3'b001);
        step(1'b1, 8'hA4, 2'd0, 3'b001);
        step(1'b0, 8'h00, 2'd0, 3'b000);
        chk("five_beats", 32'(beat_cnt), 32'd5);
        chk("all_full", 32'(out_valid), 32'h7);
        do_reset();

        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                v   = ($urandom_range(0, 3) != 0);
                d   = 8'($urandom);
                dst = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, N - 1));
            end
            step(v, d, dst, 3'($urandom));
        end
        step(1'b0, 8'h00, 2'd0, 3'b111);
        step(1'b0, 8'h00, 2'd0, 3'b111);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
